// File: rtl/dbg_pkg.sv
// Shared constants and types for the debug command receiver.
// DBG_RX_CSUM_EN adds the checksum state to the parser.
package dbg_pkg;

    localparam logic [7:0] DBG_HDR = 8'hA5;

    typedef enum logic [1:0] {
        OP_READ     = 2'd0,
        OP_WRITE    = 2'd1,
        OP_HALT_SET = 2'd2,
        OP_HALT_CLR = 2'd3
    } dbg_op_e;

    typedef enum logic [3:0] {
        P_HUNT,
        P_CMD,
        P_A2,
        P_A1,
        P_A0,
        P_D1,
        P_D0,
`ifdef DBG_RX_CSUM_EN
        P_CSUM,
`endif
        P_ISSUE
    } dbg_parse_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } dbg_rx_e;

endpackage

// File: rtl/dbg_uart_rx.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer.
// Emits one-cycle strobes for a good byte or for a byte with a low stop bit.
module dbg_uart_rx
    import dbg_pkg::*;
#(
    parameter int CLK_DIV = 434
)
(
    input  logic       clk_asic,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_stb,
    output logic       o_stop_err
);

    localparam logic [11:0] BIT_LAST  = 12'(CLK_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(CLK_DIV / 2 - 1);

    logic [2:0]  r_sync;
    dbg_rx_e     r_state;
    logic [11:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_byte_stb;
    logic        r_stop_err;

    logic w_rx;
    logic w_fall;

    // Sync chain resets low so a line held low across reset is never seen as a start edge.
    assign w_rx   = r_sync[1];
    assign w_fall = r_sync[2] & ~r_sync[1];

    always_ff @(negedge clk_asic or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= 3'b000;
            r_state    <= RX_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_byte_stb <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_sync     <= {r_sync[1:0], i_rx};
            r_byte_stb <= 1'b0;
            r_stop_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 12'd1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 12'd1;
                    end
                end
                RX_STOP: begin
                    // Returning to idle at the stop-bit centre leaves half a bit to catch the next start edge.
                    if (r_cnt == BIT_LAST) begin
                        r_cnt      <= '0;
                        r_byte_stb <= w_rx;
                        r_stop_err <= ~w_rx;
                        r_state    <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 12'd1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_byte     = r_shift;
    assign o_byte_stb = r_byte_stb;
    assign o_stop_err = r_stop_err;

endmodule

// File: rtl/dbg_cmd_rx.sv
// Debug command receiver: UART frames decoded into read/write commands and halt control.
// Define DBG_RX_CSUM_EN to require a trailing XOR checksum byte on every frame.
module dbg_cmd_rx
    import dbg_pkg::*;
#(
    parameter int CLK_DIV  = 434,
    parameter int TMO_BITS = 64
)
(
    input  logic        clk_asic,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        cmd_valid,
    output logic        cmd_we,
    output logic [1:0]  cmd_be,
    output logic [23:0] cmd_addr,
    output logic [15:0] cmd_data,
    input  logic        cmd_ack,
    output logic        dbg_halt,
    output logic        frame_err
);

    localparam logic [31:0] TMO_LAST = 32'(TMO_BITS * CLK_DIV - 1);

    logic [7:0] w_byte;
    logic       w_byte_stb;
    logic       w_stop_err;

    dbg_parse_e  r_state;
    dbg_op_e     r_op;
    logic [1:0]  r_be;
    logic [23:0] r_addr;
    logic [15:0] r_data;
    logic [31:0] r_tmo_cnt;
    logic        r_cmd_valid;
    logic        r_cmd_we;
    logic [1:0]  r_cmd_be;
    logic [23:0] r_cmd_addr;
    logic [15:0] r_cmd_data;
    logic        r_halt;
    logic        r_frame_err;

    dbg_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk_asic   (clk_asic),
        .rst_n      (rst_n),
        .i_rx       (uart_rx),
        .o_byte     (w_byte),
        .o_byte_stb (w_byte_stb),
        .o_stop_err (w_stop_err)
    );

`ifdef DBG_RX_CSUM_EN
    logic [7:0] r_csum;

    // Running XOR restarts on the CMD byte; garbage accumulated in other states is never compared.
    always_ff @(negedge clk_asic or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (w_byte_stb) begin
            r_csum <= (r_state == P_CMD) ? w_byte : (r_csum ^ w_byte);
        end
    end
`endif

    always_ff @(negedge clk_asic or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= P_HUNT;
            r_op        <= OP_READ;
            r_be        <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_tmo_cnt   <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_be    <= '0;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
            r_halt      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_cmd_valid && cmd_ack) begin
                r_cmd_valid <= 1'b0;
            end
            if (w_stop_err) begin
                r_frame_err <= 1'b1;
                r_state     <= P_HUNT;
                r_tmo_cnt   <= '0;
            end else if (w_byte_stb) begin
                r_tmo_cnt <= '0;
                if (r_cmd_valid) begin
                    r_frame_err <= 1'b1;
                    r_state     <= P_HUNT;
                end else begin
                    case (r_state)
                        P_HUNT: if (w_byte == DBG_HDR) r_state <= P_CMD;
                        P_CMD: begin
                            r_op    <= dbg_op_e'(w_byte[1:0]);
                            r_be    <= w_byte[3:2];
                            r_state <= P_A2;
                        end
                        P_A2: begin r_addr[23:16] <= w_byte; r_state <= P_A1; end
                        P_A1: begin r_addr[15:8]  <= w_byte; r_state <= P_A0; end
                        P_A0: begin r_addr[7:0]   <= w_byte; r_state <= P_D1; end
                        P_D1: begin r_data[15:8]  <= w_byte; r_state <= P_D0; end
`ifdef DBG_RX_CSUM_EN
                        P_D0: begin r_data[7:0]   <= w_byte; r_state <= P_CSUM; end
                        P_CSUM: begin
                            if (w_byte == r_csum) begin
                                r_state <= P_ISSUE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= P_HUNT;
                            end
                        end
`else
                        P_D0: begin r_data[7:0]   <= w_byte; r_state <= P_ISSUE; end
`endif
                        default: r_state <= P_HUNT;
                    endcase
                end
            end else if (r_state == P_ISSUE) begin
                if (r_op == OP_READ || r_op == OP_WRITE) begin
                    r_cmd_valid <= 1'b1;
                    r_cmd_we    <= (r_op == OP_WRITE);
                    r_cmd_be    <= r_be;
                    r_cmd_addr  <= r_addr;
                    r_cmd_data  <= r_data;
                end else begin
                    r_halt <= (r_op == OP_HALT_SET);
                end
                r_state <= P_HUNT;
            end else if (r_state != P_HUNT) begin
                if (r_tmo_cnt == TMO_LAST) begin
                    r_frame_err <= 1'b1;
                    r_state     <= P_HUNT;
                    r_tmo_cnt   <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 32'd1;
                end
            end
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_we    = r_cmd_we;
    assign cmd_be    = r_cmd_be;
    assign cmd_addr  = r_cmd_addr;
    assign cmd_data  = r_cmd_data;
    assign dbg_halt  = r_halt;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_dbg_cmd_rx.sv
// Scoreboard bench for dbg_cmd_rx: frames are serialised on uart_rx, expected commands queued,
// and a monitor compares each presented command; honours DBG_RX_CSUM_EN for the frame length.
module tb_dbg_cmd_rx;

    localparam int CLK_DIV  = 16;
    localparam int TMO_BITS = 64;
`ifdef DBG_RX_CSUM_EN
    localparam int FRAME_LEN = 8;
`else
    localparam int FRAME_LEN = 7;
`endif

    typedef struct packed {
        logic        we;
        logic [1:0]  be;
        logic [23:0] addr;
        logic [15:0] data;
    } cmdExp_t;

    logic        clk_asic = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic        cmd_valid;
    logic        cmd_we;
    logic [1:0]  cmd_be;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_ack = 1'b0;
    logic        dbg_halt;
    logic        frame_err;

    int      checks = 0;
    int      errors = 0;
    int      frameErrCount = 0;
    int      base;
    cmdExp_t expQ[$];
    cmdExp_t cur;
    logic    haveCur = 1'b0;
    logic    prevValid = 1'b0;
    logic    autoAck = 1'b0;
    logic    manualAck = 1'b0;
    logic    forceAck = 1'b0;

    dbg_cmd_rx #(.CLK_DIV(CLK_DIV), .TMO_BITS(TMO_BITS)) dut (
        .clk_asic  (clk_asic),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .cmd_valid (cmd_valid),
        .cmd_we    (cmd_we),
        .cmd_be    (cmd_be),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_ack   (cmd_ack),
        .dbg_halt  (dbg_halt),
        .frame_err (frame_err)
    );

    always #5 clk_asic = ~clk_asic;

    // Consumer model: acknowledges on the posedge so the DUT sees it on the following negedge.
    always @(posedge clk_asic) begin
        cmd_ack = forceAck || (cmd_valid && (autoAck || manualAck));
    end

    // Monitor: pops on each new command and holds the outputs to that entry while valid stays high.
    always @(posedge clk_asic) begin
        if (rst_n) begin
            if (frame_err) frameErrCount++;
            if (cmd_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_cmd got we=%0b be=%b addr=%h data=%h, required no command",
                             cmd_we, cmd_be, cmd_addr, cmd_data);
                    haveCur = 1'b0;
                end else begin
                    cur = expQ.pop_front();
                    haveCur = 1'b1;
                    checkOutput("cmd_we", 32'(cmd_we), 32'(cur.we));
                    checkOutput("cmd_be", 32'(cmd_be), 32'(cur.be));
                    checkOutput("cmd_addr", 32'(cmd_addr), 32'(cur.addr));
                    checkOutput("cmd_data", 32'(cmd_data), 32'(cur.data));
                end
            end else if (cmd_valid && haveCur) begin
                checks++;
                if ({cmd_we, cmd_be, cmd_addr, cmd_data} !== cur) begin
                    errors++;
                    $display("[TB] FAIL cmd_stable got %h required %h",
                             {cmd_we, cmd_be, cmd_addr, cmd_data}, cur);
                end
            end
        end
        prevValid = cmd_valid;
    end

    initial begin
        #600000;
        errors++;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h required %h", name, actual, expected);
        end
    endtask

    // One 8N1 character on uart_rx, leaving the line idle high afterwards.
    task automatic applyStimulus(input logic [7:0] val, input logic stopBit);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(posedge clk_asic);
        for (int i = 0; i < 8; i++) begin
            uart_rx = val[i];
            repeat (CLK_DIV) @(posedge clk_asic);
        end
        uart_rx = stopBit;
        repeat (CLK_DIV) @(posedge clk_asic);
        uart_rx = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] cmdB, input logic [23:0] addr, input logic [15:0] data,
                             input int nBytes);
        logic [7:0] bytes [8];
        bytes[0] = 8'hA5;
        bytes[1] = cmdB;
        bytes[2] = addr[23:16];
        bytes[3] = addr[15:8];
        bytes[4] = addr[7:0];
        bytes[5] = data[15:8];
        bytes[6] = data[7:0];
        bytes[7] = cmdB ^ addr[23:16] ^ addr[15:8] ^ addr[7:0] ^ data[15:8] ^ data[7:0];
        for (int i = 0; i < nBytes; i++) applyStimulus(bytes[i], 1'b1);
    endtask

    task automatic waitValid(input string name, input int budget);
        int n = 0;
        while (!cmd_valid && n < budget) begin
            @(posedge clk_asic);
            n++;
        end
        checkOutput(name, 32'(cmd_valid), 32'd1);
    endtask

    task automatic ackCommand(input string name);
        int n = 0;
        manualAck = 1'b1;
        while (cmd_valid && n < 10) begin
            @(posedge clk_asic);
            n++;
        end
        manualAck = 1'b0;
        checkOutput(name, 32'(cmd_valid), 32'd0);
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while ((expQ.size() != 0 || cmd_valid) && n < budget) begin
            @(posedge clk_asic);
            n++;
        end
        checkOutput(name, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(posedge clk_asic);
        checkOutput("rst_valid", 32'(cmd_valid), 32'd0);
        checkOutput("rst_we", 32'(cmd_we), 32'd0);
        checkOutput("rst_be", 32'(cmd_be), 32'd0);
        checkOutput("rst_addr", 32'(cmd_addr), 32'd0);
        checkOutput("rst_data", 32'(cmd_data), 32'd0);
        checkOutput("rst_halt", 32'(dbg_halt), 32'd0);
        checkOutput("rst_ferr", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (2 * CLK_DIV) @(posedge clk_asic);

        $display("[TB] write frame held until ack, with a stray ack beforehand");
        forceAck = 1'b1;
        repeat (5) @(posedge clk_asic);
        forceAck = 1'b0;
        base = frameErrCount;
        expQ.push_back({1'b1, 2'b11, 24'h012345, 16'hBEEF});
        sendFrame(8'h01 | 8'h0C, 24'h012345, 16'hBEEF, FRAME_LEN);
        waitValid("t1_valid", 200);
        repeat (30) @(posedge clk_asic);
        checkOutput("t1_held", 32'(cmd_valid), 32'd1);
        ackCommand("t1_ack_clear");
        checkOutput("t1_ferr", 32'(frameErrCount - base), 32'd0);

        $display("[TB] back-to-back read and be=0 write");
        autoAck = 1'b1;
        base = frameErrCount;
        expQ.push_back({1'b0, 2'b01, 24'hABCDEF, 16'h1234});
        expQ.push_back({1'b1, 2'b00, 24'h13579B, 16'h0F0F});
        sendFrame(8'hF4, 24'hABCDEF, 16'h1234, FRAME_LEN);
        sendFrame(8'h01, 24'h13579B, 16'h0F0F, FRAME_LEN);
        waitDrain("b2b_drain", 400);
        checkOutput("b2b_ferr", 32'(frameErrCount - base), 32'd0);
        autoAck = 1'b0;

        $display("[TB] halt set and clear");
        sendFrame(8'h02, 24'h000000, 16'h0000, FRAME_LEN);
        repeat (4) @(posedge clk_asic);
        checkOutput("halt_set", 32'(dbg_halt), 32'd1);
        sendFrame(8'h03, 24'h000000, 16'h0000, FRAME_LEN);
        repeat (4) @(posedge clk_asic);
        checkOutput("halt_clr", 32'(dbg_halt), 32'd0);

        $display("[TB] header with low stop bit, then a good frame");
        base = frameErrCount;
        applyStimulus(8'hA5, 1'b0);
        repeat (CLK_DIV) @(posedge clk_asic);
        checkOutput("stop_ferr", 32'(frameErrCount - base), 32'd1);
        expQ.push_back({1'b1, 2'b10, 24'h000001, 16'h8001});
        sendFrame(8'h09, 24'h000001, 16'h8001, FRAME_LEN);
        waitValid("stop_next_valid", 200);
        ackCommand("stop_next_ack");
        checkOutput("stop_ferr_once", 32'(frameErrCount - base), 32'd1);

        $display("[TB] inter-byte timeout");
        base = frameErrCount;
        sendFrame(8'h0D, 24'h012345, 16'hBEEF, 4);
        repeat (65 * CLK_DIV) @(posedge clk_asic);
        checkOutput("tmo_ferr", 32'(frameErrCount - base), 32'd1);
        applyStimulus(8'h45, 1'b1);
        applyStimulus(8'hBE, 1'b1);
        applyStimulus(8'hEF, 1'b1);
        repeat (10) @(posedge clk_asic);
        checkOutput("tmo_hunt_ferr", 32'(frameErrCount - base), 32'd1);
        checkOutput("tmo_no_cmd", 32'(cmd_valid), 32'd0);

        $display("[TB] second frame while first is unacked");
        expQ.push_back({1'b1, 2'b11, 24'h00FF00, 16'h1234});
        sendFrame(8'h0D, 24'h00FF00, 16'h1234, FRAME_LEN);
        waitValid("busy_valid", 200);
        base = frameErrCount;
        sendFrame(8'h05, 24'h777777, 16'h5555, FRAME_LEN);
        repeat (4) @(posedge clk_asic);
        checkOutput("busy_ferr", 32'(frameErrCount - base), 32'(FRAME_LEN));
        checkOutput("busy_addr", 32'(cmd_addr), 32'h0000FF00);
        checkOutput("busy_data", 32'(cmd_data), 32'h00001234);
        checkOutput("busy_valid_held", 32'(cmd_valid), 32'd1);
        ackCommand("busy_ack");

        $display("[TB] reset in the middle of a frame");
        sendFrame(8'h02, 24'h000000, 16'h0000, FRAME_LEN);
        repeat (4) @(posedge clk_asic);
        checkOutput("pre_rst_halt", 32'(dbg_halt), 32'd1);
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h0D, 1'b1);
        applyStimulus(8'h65, 1'b1);
        uart_rx = 1'b0;
        repeat (3 * CLK_DIV) @(posedge clk_asic);
        rst_n = 1'b0;
        repeat (5) @(posedge clk_asic);
        checkOutput("mid_rst_valid", 32'(cmd_valid), 32'd0);
        checkOutput("mid_rst_we", 32'(cmd_we), 32'd0);
        checkOutput("mid_rst_be", 32'(cmd_be), 32'd0);
        checkOutput("mid_rst_addr", 32'(cmd_addr), 32'd0);
        checkOutput("mid_rst_data", 32'(cmd_data), 32'd0);
        checkOutput("mid_rst_halt", 32'(dbg_halt), 32'd0);
        checkOutput("mid_rst_ferr", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (3 * CLK_DIV) @(posedge clk_asic);
        uart_rx = 1'b1;
        repeat (2 * CLK_DIV) @(posedge clk_asic);
        base = frameErrCount;
        expQ.push_back({1'b1, 2'b11, 24'h654321, 16'hCAFE});
        sendFrame(8'h0D, 24'h654321, 16'hCAFE, FRAME_LEN);
        waitValid("post_rst_valid", 200);
        ackCommand("post_rst_ack");
        checkOutput("post_rst_ferr", 32'(frameErrCount - base), 32'd0);
        checkOutput("post_rst_halt", 32'(dbg_halt), 32'd0);

        waitDrain("final_drain", 100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
